// File: rtl/regfile_write_arbiter.sv
// Purpose: shares one register-file write port between CPU writeback and the loader/debug port.
// Latency: an accepted request is driven on rf_* one cycle later, for exactly one cycle.
// Backpressure: ready is combinational; fixed CPU priority, ext gets forced priority after STARVE_MAX stalls.
// Optional: RF_ARB_ZERO_GUARD_EN suppresses rf_we for accepted writes to register 0.
module regfile_write_arbiter #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_valid,
   input  logic [ADDR_W-1:0] cpu_wr,
   input  logic [DATA_W-1:0] cpu_wd,
   output logic              cpu_ready,
   input  logic              ext_valid,
   input  logic [ADDR_W-1:0] ext_wr,
   input  logic [DATA_W-1:0] ext_wd,
   output logic              ext_ready,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_wr,
   output logic [DATA_W-1:0] rf_wd,
   output logic              rf_src
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   typedef enum logic {
      PRI_CPU = 1'b0,
      PRI_EXT = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] starve_cnt;
   logic [CNT_W-1:0] starve_cnt_nxt;
   logic             cpu_acc;
   logic             ext_acc;
   logic             starve_inc;
   logic             starve_hit;
   logic             cpu_we_ok;
   logic             ext_we_ok;

   assign cpu_acc = cpu_valid & cpu_ready;
   assign ext_acc = ext_valid & ext_ready;

   // ext is stalled while CPU holds priority; count it until the limit.
   assign starve_inc = (state == PRI_CPU) & ext_valid & ~ext_ready & (starve_cnt != STARVE_LIM);
   // The increment that lands exactly on the limit flips priority on the same edge.
   assign starve_hit = starve_inc & (starve_cnt == (STARVE_LIM - CNT_W'(1)));

`ifdef RF_ARB_ZERO_GUARD_EN
   // r0 is hardwired zero: the handshake completes but the write is dropped.
   assign cpu_we_ok = (cpu_wr != '0);
   assign ext_we_ok = (ext_wr != '0);
`else
   assign cpu_we_ok = 1'b1;
   assign ext_we_ok = 1'b1;
`endif

   // Priority state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= PRI_CPU;
      end else begin
         state <= state_nxt;
      end
   end

   // Next priority: go to ext on starvation, return after one ext grant or if ext withdraws.
   always_comb begin
      state_nxt = state;
      case (state)
         PRI_CPU: if (starve_hit) state_nxt = PRI_EXT;
         PRI_EXT: if (ext_acc || !ext_valid) state_nxt = PRI_CPU;
         default: state_nxt = PRI_CPU;
      endcase
   end

   // Grant decode; both readies are held low during reset.
   always_comb begin
      cpu_ready = 1'b0;
      ext_ready = 1'b0;
      if (!rst) begin
         case (state)
            PRI_CPU: begin
               cpu_ready = cpu_valid;
               ext_ready = ext_valid & ~cpu_valid;
            end
            PRI_EXT: begin
               ext_ready = ext_valid;
               cpu_ready = cpu_valid & ~ext_valid;
            end
            default: begin
               cpu_ready = 1'b0;
               ext_ready = 1'b0;
            end
         endcase
      end
   end

   // Starvation counter: clears when ext is served or stops asking, saturates at the limit.
   always_comb begin
      starve_cnt_nxt = starve_cnt;
      if (ext_acc || !ext_valid) begin
         starve_cnt_nxt = '0;
      end else if (starve_inc) begin
         starve_cnt_nxt = starve_cnt + CNT_W'(1);
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else begin
         starve_cnt <= starve_cnt_nxt;
      end
   end

   // Register-file port: one-cycle write pulse, address/data/source hold when idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we  <= 1'b0;
         rf_wr  <= '0;
         rf_wd  <= '0;
         rf_src <= 1'b0;
      end else if (cpu_acc) begin
         rf_we  <= cpu_we_ok;
         rf_wr  <= cpu_wr;
         rf_wd  <= cpu_wd;
         rf_src <= 1'b0;
      end else if (ext_acc) begin
         rf_we  <= ext_we_ok;
         rf_wr  <= ext_wr;
         rf_wd  <= ext_wd;
         rf_src <= 1'b1;
      end else begin
         rf_we  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Purpose: directed vector table plus a contention sequence for regfile_write_arbiter.
// Latency: expects rf_* to show the previous cycle's acceptance.
// Backpressure: checks combinational readies against hand-derived grant patterns.
module tb_regfile_write_arbiter;

   localparam int DW = 32;
   localparam int AW = 5;

`ifdef RF_ARB_ZERO_GUARD_EN
   localparam bit ZG = 1'b1;
`else
   localparam bit ZG = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          cpu_valid;
   logic [AW-1:0] cpu_wr;
   logic [DW-1:0] cpu_wd;
   logic          cpu_ready;
   logic          ext_valid;
   logic [AW-1:0] ext_wr;
   logic [DW-1:0] ext_wd;
   logic          ext_ready;
   logic          rf_we;
   logic [AW-1:0] rf_wr;
   logic [DW-1:0] rf_wd;
   logic          rf_src;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_valid (cpu_valid),
      .cpu_wr    (cpu_wr),
      .cpu_wd    (cpu_wd),
      .cpu_ready (cpu_ready),
      .ext_valid (ext_valid),
      .ext_wr    (ext_wr),
      .ext_wd    (ext_wd),
      .ext_ready (ext_ready),
      .rf_we     (rf_we),
      .rf_wr     (rf_wr),
      .rf_wd     (rf_wd),
      .rf_src    (rf_src)
   );

   typedef struct {
      logic          rst;
      logic          cv;
      logic [AW-1:0] cwr;
      logic [DW-1:0] cwd;
      logic          ev;
      logic [AW-1:0] ewr;
      logic [DW-1:0] ewd;
      logic          e_cr;
      logic          e_er;
      logic          chk_rf;
      logic          e_we;
      logic [AW-1:0] e_wr;
      logic [DW-1:0] e_wd;
      logic          e_src;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic r, logic cv, logic [AW-1:0] cwr, logic [DW-1:0] cwd,
                               logic ev, logic [AW-1:0] ewr, logic [DW-1:0] ewd,
                               logic e_cr, logic e_er, logic chk_rf,
                               logic e_we, logic [AW-1:0] e_wr, logic [DW-1:0] e_wd, logic e_src);
      vec_t v;
      v.rst = r;  v.cv = cv;  v.cwr = cwr;  v.cwd = cwd;
      v.ev = ev;  v.ewr = ewr;  v.ewd = ewd;
      v.e_cr = e_cr;  v.e_er = e_er;  v.chk_rf = chk_rf;
      v.e_we = e_we;  v.e_wr = e_wr;  v.e_wd = e_wd;  v.e_src = e_src;
      return v;
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", name, act, exp);
      end
   endtask

   initial begin
      logic       prev_g;
      logic [DW-1:0] prev_wd;
      logic       g;

      rst = 1'b1; cpu_valid = 1'b0; cpu_wr = '0; cpu_wd = '0;
      ext_valid = 1'b0; ext_wr = '0; ext_wd = '0;

      //            rst cv cwr  cwd      ev ewr  ewd        cr er chk we wr   wd         src
      // reset held with both requesters active
      vecs.push_back(mk(1, 1, 5'd1, 32'h11, 1, 5'd2, 32'h22,     0, 0, 0, 0, 5'd0, 32'h0,    0));
      vecs.push_back(mk(1, 1, 5'd1, 32'h11, 1, 5'd2, 32'h22,     0, 0, 1, 0, 5'd0, 32'h0,    0));
      vecs.push_back(mk(1, 1, 5'd1, 32'h11, 1, 5'd2, 32'h22,     0, 0, 1, 0, 5'd0, 32'h0,    0));
      // CPU only, then idle (hold)
      vecs.push_back(mk(0, 1, 5'd1, 32'h5,  0, 5'd0, 32'h0,      1, 0, 1, 0, 5'd0, 32'h0,    0));
      vecs.push_back(mk(0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,      0, 0, 1, 1, 5'd1, 32'h5,    0));
      vecs.push_back(mk(0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,      0, 0, 1, 0, 5'd1, 32'h5,    0));
      // contention: 4 CPU grants, 1 ext grant, repeat
      vecs.push_back(mk(0, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44,     1, 0, 1, 0, 5'd1, 32'h5,    0));
      vecs.push_back(mk(0, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44,     1, 0, 1, 1, 5'd3, 32'h33,   0));
      vecs.push_back(mk(0, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44,     1, 0, 1, 1, 5'd3, 32'h33,   0));
      vecs.push_back(mk(0, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44,     1, 0, 1, 1, 5'd3, 32'h33,   0));
      vecs.push_back(mk(0, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44,     0, 1, 1, 1, 5'd3, 32'h33,   0));
      vecs.push_back(mk(0, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44,     1, 0, 1, 1, 5'd4, 32'h44,   1));
      vecs.push_back(mk(0, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44,     1, 0, 1, 1, 5'd3, 32'h33,   0));
      vecs.push_back(mk(0, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44,     1, 0, 1, 1, 5'd3, 32'h33,   0));
      vecs.push_back(mk(0, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44,     1, 0, 1, 1, 5'd3, 32'h33,   0));
      vecs.push_back(mk(0, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44,     0, 1, 1, 1, 5'd3, 32'h33,   0));
      vecs.push_back(mk(0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,      0, 0, 1, 1, 5'd4, 32'h44,   1));
      // ext drops after 2 stalled cycles: counter restarts, no early ext grant
      vecs.push_back(mk(0, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44,     1, 0, 1, 0, 5'd4, 32'h44,   1));
      vecs.push_back(mk(0, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44,     1, 0, 1, 1, 5'd3, 32'h33,   0));
      vecs.push_back(mk(0, 1, 5'd3, 32'h33, 0, 5'd4, 32'h44,     1, 0, 1, 1, 5'd3, 32'h33,   0));
      vecs.push_back(mk(0, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44,     1, 0, 1, 1, 5'd3, 32'h33,   0));
      vecs.push_back(mk(0, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44,     1, 0, 1, 1, 5'd3, 32'h33,   0));
      vecs.push_back(mk(0, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44,     1, 0, 1, 1, 5'd3, 32'h33,   0));
      vecs.push_back(mk(0, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44,     1, 0, 1, 1, 5'd3, 32'h33,   0));
      // now in ext priority: reset mid-operation, pending ext write is dropped
      vecs.push_back(mk(1, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44,     0, 0, 1, 1, 5'd3, 32'h33,   0));
      vecs.push_back(mk(0, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44,     1, 0, 1, 0, 5'd0, 32'h0,    0));
      vecs.push_back(mk(0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,      0, 0, 1, 1, 5'd3, 32'h33,   0));
      // ext write to r0
      vecs.push_back(mk(0, 0, 5'd0, 32'h0,  1, 5'd0, 32'hDEAD,   0, 1, 1, 0, 5'd3, 32'h33,   0));
      vecs.push_back(mk(0, 0, 5'd0, 32'h0,  1, 5'd7, 32'h77,     0, 1, 1, !ZG, 5'd0, 32'hDEAD, 1));
      vecs.push_back(mk(0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,      0, 0, 1, 1, 5'd7, 32'h77,   1));

      foreach (vecs[i]) begin
         rst       = vecs[i].rst;
         cpu_valid = vecs[i].cv;
         cpu_wr    = vecs[i].cwr;
         cpu_wd    = vecs[i].cwd;
         ext_valid = vecs[i].ev;
         ext_wr    = vecs[i].ewr;
         ext_wd    = vecs[i].ewd;
         @(negedge clk);
         chk($sformatf("v%0d.cpu_ready", i), DW'(cpu_ready), DW'(vecs[i].e_cr));
         chk($sformatf("v%0d.ext_ready", i), DW'(ext_ready), DW'(vecs[i].e_er));
         if (vecs[i].chk_rf) begin
            chk($sformatf("v%0d.rf_we", i),  DW'(rf_we),  DW'(vecs[i].e_we));
            chk($sformatf("v%0d.rf_wr", i),  DW'(rf_wr),  DW'(vecs[i].e_wr));
            chk($sformatf("v%0d.rf_wd", i),  rf_wd,       vecs[i].e_wd);
            chk($sformatf("v%0d.rf_src", i), DW'(rf_src), DW'(vecs[i].e_src));
         end
         @(posedge clk);
         #1;
      end

      // Long contention with changing payload: ext wins every fifth cycle.
      prev_g  = 1'b0;
      prev_wd = '0;
      for (int k = 0; k < 20; k++) begin
         rst       = 1'b0;
         cpu_valid = 1'b1;
         cpu_wr    = 5'd10;
         cpu_wd    = DW'(100 + k);
         ext_valid = 1'b1;
         ext_wr    = 5'd20;
         ext_wd    = DW'(200 + k);
         g = ((k % 5) == 4);
         @(negedge clk);
         chk($sformatf("seq%0d.cpu_ready", k), DW'(cpu_ready), DW'(!g));
         chk($sformatf("seq%0d.ext_ready", k), DW'(ext_ready), DW'(g));
         if (k > 0) begin
            chk($sformatf("seq%0d.rf_we", k),  DW'(rf_we),  DW'(1'b1));
            chk($sformatf("seq%0d.rf_src", k), DW'(rf_src), DW'(prev_g));
            chk($sformatf("seq%0d.rf_wr", k),  DW'(rf_wr),  prev_g ? DW'(20) : DW'(10));
            chk($sformatf("seq%0d.rf_wd", k),  rf_wd,       prev_wd);
         end
         prev_g  = g;
         prev_wd = g ? DW'(200 + k) : DW'(100 + k);
         @(posedge clk);
         #1;
      end
      cpu_valid = 1'b0;
      ext_valid = 1'b0;
      @(negedge clk);
      chk("seq_end.rf_we",  DW'(rf_we),  DW'(1'b1));
      chk("seq_end.rf_src", DW'(rf_src), DW'(prev_g));
      chk("seq_end.rf_wd",  rf_wd,       prev_wd);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("idle.rf_we", DW'(rf_we), DW'(1'b0));
      chk("idle.rf_wd", rf_wd,      prev_wd);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
